// File: rtl/dm_dma_arbiter.sv
// Data-memory arbiter: the CPU has absolute priority, and a background DMA copies
// a block one byte at a time (read, then write) during idle memory cycles.
module dm_dma_arbiter #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_gnt,
    input  logic          dma_start,
    input  logic [AW-1:0] dma_src,
    input  logic [AW-1:0] dma_dst,
    input  logic [AW-1:0] dma_len,
    output logic          dma_busy,
    output logic          dma_done,
    output logic [AW-1:0] mem_adr,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } stateT;

    stateT         stateQ;
    stateT         stateD;
    logic [AW-1:0] srcQ;
    logic [AW-1:0] dstQ;
    logic [AW-1:0] lenQ;
    logic [AW-1:0] idxQ;
    logic [7:0]    byteQ;
    logic          lastByte;

    assign lastByte = (idxQ == lenQ - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Datapath only moves on cycles the CPU leaves the memory alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            srcQ  <= '0;
            dstQ  <= '0;
            lenQ  <= '0;
            idxQ  <= '0;
            byteQ <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (dma_start) begin
                        srcQ <= dma_src;
                        dstQ <= dma_dst;
                        lenQ <= dma_len;
                        idxQ <= '0;
                    end
                end
                READ: begin
                    if (!cpu_req) begin
                        byteQ <= mem_dout;
                    end
                end
                WRITE: begin
                    if (!cpu_req) begin
                        idxQ <= idxQ + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (dma_start) begin
                    stateD = (dma_len != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (!cpu_req) begin
                    stateD = WRITE;
                end
            end
            WRITE: begin
                if (!cpu_req) begin
                    stateD = lastByte ? DONE : READ;
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt  = cpu_req;
        cpu_dout = (cpu_req && !cpu_we) ? mem_dout : 8'h00;
        dma_busy = (stateQ == READ) || (stateQ == WRITE);
        dma_done = (stateQ == DONE);
        mem_adr  = '0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_din  = '0;
        if (cpu_req) begin
            mem_adr = cpu_adr;
            mem_wen = cpu_we;
            mem_ren = !cpu_we;
            mem_din = cpu_din;
        end else if (stateQ == READ) begin
            mem_adr = srcQ + idxQ;
            mem_ren = 1'b1;
        end else if (stateQ == WRITE) begin
            mem_adr = dstQ + idxQ;
            mem_wen = 1'b1;
            mem_din = byteQ;
        end
    end

endmodule

// File: tb/tb_dm_dma_arbiter.sv
// Directed bench for dm_dma_arbiter with a behavioural 256-byte data memory
// attached to the memory port.
module tb_dm_dma_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_adr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_gnt;
    logic       dma_start;
    logic [7:0] dma_src;
    logic [7:0] dma_dst;
    logic [7:0] dma_len;
    logic       dma_busy;
    logic       dma_done;
    logic [7:0] mem_adr;
    logic       mem_ren;
    logic       mem_wen;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    int busyCnt;
    int doneCnt;
    int doneCyc;
    int bothCnt;
    int dmaAccCnt;

    always #5 clk = ~clk;

    dm_dma_arbiter #(.AW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_adr  (cpu_adr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_gnt  (cpu_gnt),
        .dma_start(dma_start),
        .dma_src  (dma_src),
        .dma_dst  (dma_dst),
        .dma_len  (dma_len),
        .dma_busy (dma_busy),
        .dma_done (dma_done),
        .mem_adr  (mem_adr),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_adr] <= mem_din;
    end
    assign mem_dout = mem_ren ? mem[mem_adr] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_adr   = 8'h00;
        cpu_din   = 8'h00;
        dma_start = 1'b0;
        dma_src   = 8'h00;
        dma_dst   = 8'h00;
        dma_len   = 8'h00;
    endtask

    task automatic cpuWrite(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        idleInputs();
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        cpu_adr = a;
        cpu_din = d;
        @(negedge clk);
        idleInputs();
    endtask

    // Starts a copy and watches up to 30 cycles; optional CPU burst, restart pulse
    // or reset at given cycle numbers (0 = unused). Cycle 1 follows the start edge.
    task automatic runCopy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input int cpuAt, input int restartAt, input int rstAt);
        busyCnt   = 0;
        doneCnt   = 0;
        doneCyc   = 0;
        bothCnt   = 0;
        dmaAccCnt = 0;
        @(negedge clk);
        idleInputs();
        rst_n     = 1'b1;
        dma_start = 1'b1;
        dma_src   = s;
        dma_dst   = d;
        dma_len   = l;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            idleInputs();
            rst_n = 1'b1;
            if (cyc == restartAt) begin
                dma_start = 1'b1;
                dma_src   = 8'h00;
                dma_dst   = 8'hC0;
                dma_len   = 8'h02;
            end
            if (cpuAt > 0 && cyc >= cpuAt && cyc <= cpuAt + 4) begin
                cpu_req = 1'b1;
                cpu_adr = 8'h20;
                cpu_we  = (cyc == cpuAt);
                cpu_din = 8'h5A;
            end
            if (rstAt > 0 && cyc == rstAt) rst_n = 1'b0;
            #1;
            if (dma_busy) busyCnt++;
            if (dma_done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (mem_ren && mem_wen) bothCnt++;
            if (!cpu_req && (mem_ren || mem_wen)) dmaAccCnt++;
            if (cpu_req) begin
                chk("cpu_gnt_during_copy", cpu_gnt, 1);
                if (!cpu_we) chk("cpu_load_0x20", cpu_dout, 8'h5A);
            end
            if (rstAt > 0 && cyc == rstAt + 1) begin
                chk("post_abort_busy", dma_busy, 0);
                chk("post_abort_done", dma_done, 0);
                chk("post_abort_ren", mem_ren, 0);
                chk("post_abort_wen", mem_wen, 0);
                chk("post_abort_adr", mem_adr, 0);
                chk("post_abort_din", mem_din, 0);
                chk("post_abort_dout", cpu_dout, 0);
                chk("post_abort_gnt", cpu_gnt, 0);
            end
        end
    endtask

    initial begin
        idleInputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", dma_busy, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_adr", mem_adr, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_dout", cpu_dout, 0);
        chk("rst_gnt_low", cpu_gnt, 0);
        cpu_req = 1'b1;
        cpu_adr = 8'h33;
        #1;
        chk("rst_gnt_follows_req", cpu_gnt, 1);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;

        // CPU store in IDLE drives the memory port directly
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        cpu_adr = 8'h10;
        cpu_din = 8'h11;
        #1;
        chk("cpu_st_gnt", cpu_gnt, 1);
        chk("cpu_st_wen", mem_wen, 1);
        chk("cpu_st_ren", mem_ren, 0);
        chk("cpu_st_adr", mem_adr, 8'h10);
        chk("cpu_st_din", mem_din, 8'h11);
        chk("cpu_st_dout", cpu_dout, 8'h00);
        cpuWrite(8'h11, 8'h22);
        cpuWrite(8'h12, 8'h33);
        cpuWrite(8'h13, 8'h44);
        for (int i = 0; i < 4; i++) cpuWrite(8'h80 + 8'(i), 8'hEE);
        cpuWrite(8'hFE, 8'hA1);
        cpuWrite(8'hFF, 8'hA2);
        cpuWrite(8'h00, 8'hA3);
        for (int i = 0; i < 3; i++) cpuWrite(8'h40 + 8'(i), 8'hEE);
        cpuWrite(8'hC0, 8'hEE);
        cpuWrite(8'hC1, 8'hEE);

        @(negedge clk);
        cpu_req = 1'b1;
        cpu_adr = 8'h11;
        #1;
        chk("cpu_ld_ren", mem_ren, 1);
        chk("cpu_ld_dout", cpu_dout, 8'h22);

        // Plain 4-byte copy
        runCopy(8'h10, 8'h80, 8'd4, 0, 0, 0);
        chk("basic_busy_cycles", busyCnt, 8);
        chk("basic_done_count", doneCnt, 1);
        chk("basic_done_cycle", doneCyc, 9);
        chk("basic_ren_wen_both", bothCnt, 0);
        chk("basic_m80", mem[8'h80], 8'h11);
        chk("basic_m81", mem[8'h81], 8'h22);
        chk("basic_m82", mem[8'h82], 8'h33);
        chk("basic_m83", mem[8'h83], 8'h44);

        // Empty copy
        runCopy(8'h10, 8'h90, 8'd0, 0, 0, 0);
        chk("len0_busy_cycles", busyCnt, 0);
        chk("len0_done_count", doneCnt, 1);
        chk("len0_done_cycle", doneCyc, 1);
        chk("len0_mem_access", dmaAccCnt, 0);

        // Source wraps past 0xFF
        runCopy(8'hFE, 8'h40, 8'd3, 0, 0, 0);
        chk("wrap_done_cycle", doneCyc, 7);
        chk("wrap_m40", mem[8'h40], 8'hA1);
        chk("wrap_m41", mem[8'h41], 8'hA2);
        chk("wrap_m42", mem[8'h42], 8'hA3);

        // CPU burst of 5 cycles stalls the copy by 5
        for (int i = 0; i < 4; i++) cpuWrite(8'h80 + 8'(i), 8'hEE);
        runCopy(8'h10, 8'h80, 8'd4, 3, 0, 0);
        chk("stall_busy_cycles", busyCnt, 13);
        chk("stall_done_cycle", doneCyc, 14);
        chk("stall_done_count", doneCnt, 1);
        chk("stall_ren_wen_both", bothCnt, 0);
        chk("stall_m20", mem[8'h20], 8'h5A);
        chk("stall_m80", mem[8'h80], 8'h11);
        chk("stall_m81", mem[8'h81], 8'h22);
        chk("stall_m82", mem[8'h82], 8'h33);
        chk("stall_m83", mem[8'h83], 8'h44);

        // Mid-copy restart is ignored
        for (int i = 0; i < 4; i++) cpuWrite(8'h80 + 8'(i), 8'hEE);
        runCopy(8'h10, 8'h80, 8'd4, 0, 3, 0);
        chk("restart_done_cycle", doneCyc, 9);
        chk("restart_done_count", doneCnt, 1);
        chk("restart_m83", mem[8'h83], 8'h44);
        chk("restart_mC0", mem[8'hC0], 8'hEE);
        chk("restart_mC1", mem[8'hC1], 8'hEE);

        // Reset after the second byte is written aborts the copy
        for (int i = 0; i < 4; i++) cpuWrite(8'h80 + 8'(i), 8'hEE);
        runCopy(8'h10, 8'h80, 8'd4, 0, 0, 5);
        chk("abort_done_count", doneCnt, 0);
        chk("abort_busy_cycles", busyCnt, 5);
        chk("abort_m80", mem[8'h80], 8'h11);
        chk("abort_m81", mem[8'h81], 8'h22);
        chk("abort_m82", mem[8'h82], 8'hEE);
        chk("abort_m83", mem[8'h83], 8'hEE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_dma_arbiter.md
DM_DMA_ARBITER -- requirements
Module: dm_dma_arbiter

Interface
REQ-001 Parameter: AW, default 8, data-memory address width; memory depth is 2**AW bytes.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cpu_req  input  1  CPU requests a memory access this cycle.
REQ-005 cpu_we  input  1  CPU access is a store (1) or a load (0).
REQ-006 cpu_adr  input  AW  CPU byte address.
REQ-007 cpu_din  input  8  CPU store data.
REQ-008 cpu_dout  output  8  CPU load data.
REQ-009 cpu_gnt  output  1  CPU owns the memory this cycle.
REQ-010 dma_start  input  1  one-cycle request to begin a block copy.
REQ-011 dma_src  input  AW  copy source base address, sampled with dma_start.
REQ-012 dma_dst  input  AW  copy destination base address, sampled with dma_start.
REQ-013 dma_len  input  AW  byte count, sampled with dma_start; 0 = empty copy.
REQ-014 dma_busy  output  1  copy in progress.
REQ-015 dma_done  output  1  one-cycle pulse at copy completion.
REQ-016 mem_adr  output  AW  data-memory address.
REQ-017 mem_ren  output  1  data-memory read enable.
REQ-018 mem_wen  output  1  data-memory write enable.
REQ-019 mem_din  output  8  data-memory write data.
REQ-020 mem_dout  input  8  data-memory read data; combinational with respect to mem_adr/mem_ren.

Function
REQ-021 FSM states: IDLE, READ, WRITE, DONE; dma_busy = (state is READ or WRITE), combinational.
REQ-022 CPU has absolute priority: cpu_gnt = cpu_req, combinational, in every state.
REQ-023 Granted CPU cycle: mem_adr = cpu_adr, mem_wen = cpu_we, mem_ren = !cpu_we, mem_din = cpu_din, cpu_dout = mem_dout; the DMA holds all state.
REQ-024 If cpu_req = 0 and the state is IDLE or DONE: mem_ren = 0, mem_wen = 0; cpu_dout = 8'h00 whenever not (cpu_req & !cpu_we).
REQ-025 IDLE: if dma_start = 1, latch src, dst, len, clear idx; go to READ if len != 0, else go to DONE.
REQ-026 dma_start is ignored in READ, WRITE and DONE; a new copy cannot begin before returning to IDLE.
REQ-027 READ, cpu_req = 0: mem_adr = src+idx, mem_ren = 1; capture mem_dout into the byte register at the edge; go to WRITE.
REQ-028 WRITE, cpu_req = 0: mem_adr = dst+idx, mem_wen = 1, mem_din = byte register; at the edge, increment idx; go to DONE if idx == len-1, else go to READ.
REQ-029 READ or WRITE with cpu_req = 1: no DMA memory access, no state change (stall); unbounded CPU traffic stalls the DMA indefinitely.
REQ-030 Address arithmetic is modulo 2**AW: src+idx and dst+idx wrap past 2**AW-1 to 0.
REQ-031 Overlapping regions: the copy is strictly forward, one byte read then written per idx; the result is defined by that order.
REQ-032 DONE: dma_done = 1 for exactly this cycle; unconditional transition to IDLE.
REQ-033 Uncontended latency: for dma_start sampled at edge E0 with len = N > 0, dma_busy is high for 2N cycles and dma_done is high in the cycle after edge E(2N); for len = 0, dma_done is high in the cycle after E0.
REQ-034 Each cycle, at most one of mem_ren and mem_wen is 1.

Reset
REQ-035 When rst_n = 0 at a rising edge: state = IDLE, and idx, src, dst, len and the byte register are cleared to 0.
REQ-036 Outputs after reset: dma_busy = 0, dma_done = 0, mem_ren = 0, mem_wen = 0, mem_adr = 0, mem_din = 0, cpu_dout = 0, cpu_gnt = cpu_req.
REQ-037 Reset during a copy aborts it with no further memory writes and no dma_done pulse; bytes already written remain.

Verification
REQ-038 Preload M[0x10..0x13] = 11,22,33,44; start src = 0x10, dst = 0x80, len = 4, no CPU traffic -> M[0x80..0x83] = 11,22,33,44; busy for 8 cycles; done pulses once.
REQ-039 Start with len = 0 -> dma_done is high in the cycle after start; no mem_ren or mem_wen; busy never rises.
REQ-040 src = 0xFE, dst = 0x40, len = 3, M[0xFE] = A1, M[0xFF] = A2, M[0x00] = A3 -> M[0x40..0x42] = A1,A2,A3, proving wrap-around.
REQ-041 During the copy of REQ-038, hold cpu_req high for 5 cycles with a store to 0x20 and then a load of 0x20 -> cpu_gnt is high every requested cycle, the load returns the stored value, the copy result is unchanged, and done is delayed by exactly 5 cycles.
REQ-042 Pulse dma_start again mid-copy with different arguments -> ignored; the original copy completes unchanged.
REQ-043 Assert rst_n = 0 after the second byte is written with len = 4 -> only the first two destination bytes change, no done pulse, and outputs match REQ-036 in the next cycle.
